// File: rtl/tqvp_htfab_sar_adc.sv
// Successive-approximation ADC peripheral: PWM/RC DAC out on uo_out[1], comparator in on ui_in[CH].
// Optional build macro ANATOOL_SAR_MAJORITY_EN: 2-of-3 majority decision over the last three cycles of a bit.
module tqvp_htfab_sar_adc #(
  parameter int PWM_BITS       = 8,
  parameter int DEFAULT_SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state_q, state_d;
  logic [2:0]          ch_q, ch_d;
  logic                cont_q, cont_d;
  logic [7:0]          settle_q, settle_d;
  logic [7:0]          result_q, result_d;
  logic [7:0]          work_q, work_d;
  logic [2:0]          bitIdx_q, bitIdx_d;
  logic                done_q, done_d;
  logic [PWM_BITS-1:0] pwmCnt_q, pwmCnt_d;
  logic [7:0]          periodCnt_q, periodCnt_d;
  logic [7:0]          bitSettle_q, bitSettle_d;

  logic       busy;
  logic       ctrlWrite;
  logic       startReq;
  logic       pwmWrap;
  logic       bitLast;
  logic       comp;
  logic       decision;
  logic [7:0] trial;
  logic [7:0] dacCode;
  logic [7:0] effSettle;

  assign busy      = (state_q == CONV);
  assign ctrlWrite = data_write && (address == 4'd0);
  assign startReq  = ctrlWrite && data_in[0];
  assign pwmWrap   = (pwmCnt_q == {PWM_BITS{1'b1}});
  assign bitLast   = busy && pwmWrap && (periodCnt_q == bitSettle_q - 8'd1);
  assign comp      = ui_in[ch_q];
  assign trial     = work_q | (8'd1 << bitIdx_q);
  assign dacCode   = busy ? trial : result_q;
  assign effSettle = (settle_q == 8'd0) ? 8'd1 : settle_q;

`ifdef ANATOOL_SAR_MAJORITY_EN
  // Comparator history of the two preceding cycles; every bit spans at least one full PWM period,
  // so at the decision cycle both samples belong to the current bit.
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 2'b00;
    else     hist_q <= {hist_q[0], comp};
  end

  assign decision = (hist_q[1] & hist_q[0]) | (hist_q[1] & comp) | (hist_q[0] & comp);
`else
  assign decision = comp;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= 3'd0;
      cont_q      <= 1'b0;
      settle_q    <= 8'(DEFAULT_SETTLE);
      result_q    <= 8'd0;
      work_q      <= 8'd0;
      bitIdx_q    <= 3'd7;
      done_q      <= 1'b0;
      pwmCnt_q    <= '0;
      periodCnt_q <= 8'd0;
      bitSettle_q <= 8'd1;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cont_q      <= cont_d;
      settle_q    <= settle_d;
      result_q    <= result_d;
      work_q      <= work_d;
      bitIdx_q    <= bitIdx_d;
      done_q      <= done_d;
      pwmCnt_q    <= pwmCnt_d;
      periodCnt_q <= periodCnt_d;
      bitSettle_q <= bitSettle_d;
    end
  end

  // Order matters: completion overrides a DONE-clearing STATUS write, and a start overrides everything.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cont_d      = cont_q;
    settle_d    = settle_q;
    result_d    = result_q;
    work_d      = work_q;
    bitIdx_d    = bitIdx_q;
    done_d      = done_q;
    pwmCnt_d    = pwmCnt_q + 1'b1;
    periodCnt_d = periodCnt_q;
    bitSettle_d = bitSettle_q;

    if (ctrlWrite)                            cont_d   = data_in[4];
    if (data_write && (address == 4'd1))      settle_d = data_in;
    if (data_write && (address == 4'd3))      done_d   = 1'b0;

    case (state_q)
      CONV: begin
        if (bitLast) begin
          work_d      = decision ? trial : work_q;
          periodCnt_d = 8'd0;
          bitSettle_d = effSettle;
          if (bitIdx_q == 3'd0) begin
            result_d = decision ? trial : work_q;
            done_d   = 1'b1;
            work_d   = 8'd0;
            bitIdx_d = 3'd7;
            if (!cont_q) state_d = IDLE;
          end else begin
            bitIdx_d = bitIdx_q - 3'd1;
          end
        end else if (pwmWrap) begin
          periodCnt_d = periodCnt_q + 8'd1;
        end
      end
      default: ;
    endcase

    if (startReq) begin
      state_d     = CONV;
      ch_d        = data_in[3:1];
      result_d    = result_q;
      work_d      = 8'd0;
      bitIdx_d    = 3'd7;
      done_d      = 1'b0;
      pwmCnt_d    = '0;
      periodCnt_d = 8'd0;
      bitSettle_d = effSettle;
    end
  end

  always_comb begin
    data_out = 8'd0;
    case (address)
      4'd0:    data_out = {3'b000, cont_q, ch_q, 1'b0};
      4'd1:    data_out = settle_q;
      4'd2:    data_out = result_q;
      4'd3:    data_out = {6'b000000, done_q, busy};
      default: data_out = 8'd0;
    endcase
  end

  assign uo_out = {4'b0000, bitLast, busy, (pwmCnt_q < PWM_BITS'(dacCode)), 1'b0};

endmodule

// File: tb/tb_tqvp_htfab_sar_adc.sv
// Bench for tqvp_htfab_sar_adc: an RC-filter comparator model averages the PWM output over the last
// 256 cycles and compares it with a threshold; a SAR with a ">=" comparator must converge to that threshold.
module tb_tqvp_htfab_sar_adc;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  int         edgeCnt = 0;
  int         startEdge = 0;
  int         period = 256;
  int         threshold = 0;
  int         chSel = 0;
  bit         tieLow = 1'b0;
  bit         glitchEn = 1'b0;
  int         strobeCnt = 0;
  logic [255:0] win = '0;
  logic [7:0] expResult = 8'h00;

  tqvp_htfab_sar_adc dut (
    .clk        (clk),
    .rst        (rst),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Comparator environment: filtered DAC level is the high count of the last 256 PWM samples.
  always @(negedge clk) begin
    logic [7:0] ui;
    int cnt;
    win = {win[254:0], uo_out[1]};
    cnt = $countones(win);
    ui = 8'($urandom);
    ui[chSel] = (threshold >= cnt) && !tieLow;
    if (glitchEn && (((edgeCnt - startEdge) % period) == period - 1)) ui[chSel] = 1'b0;
    ui_in = ui;
    if (uo_out[3]) strobeCnt++;
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic writeReg(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    data_write = 1'b1;
    @(posedge clk);
    #1;
    startEdge = edgeCnt;
    data_write = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] a, output logic [7:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  // Start a conversion and check the RESULT boundary: unchanged one edge early, updated on the edge.
  task automatic applyStimulus(input int s, input int thr, input int ch, input bit cont,
                               input logic [7:0] exp, input string tag);
    logic [7:0] d;
    int total;
    writeReg(4'd1, 8'(s));
    threshold = thr;
    chSel = ch;
    period = ((s == 0) ? 1 : s) * 256;
    total = 8 * period;
    strobeCnt = 0;
    writeReg(4'd0, {3'b000, cont, 3'(ch), 1'b1});
    checkOutput({tag, "_busy"}, {7'd0, uo_out[2]}, 8'h01);
    repeat (total - 1) @(posedge clk);
    #1;
    readReg(4'd2, d);
    checkOutput({tag, "_early_result"}, d, expResult);
    readReg(4'd3, d);
    checkOutput({tag, "_early_status"}, d, 8'h01);
    @(posedge clk);
    #1;
    readReg(4'd2, d);
    checkOutput({tag, "_result"}, d, exp);
    readReg(4'd3, d);
    checkOutput({tag, "_status"}, d, {6'd0, 1'b1, cont});
    expResult = exp;
  endtask

  initial begin
    logic [7:0] d;
    int busyLow;
    int highs;
    int thr;
    logic [7:0] expG;

    rst = 1'b1;
    address = 4'd0;
    data_write = 1'b0;
    data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset_uo_out", uo_out, 8'h00);
    readReg(4'd0, d); checkOutput("reset_ctrl", d, 8'h00);
    readReg(4'd1, d); checkOutput("reset_settle", d, 8'h04);
    readReg(4'd2, d); checkOutput("reset_result", d, 8'h00);
    readReg(4'd3, d); checkOutput("reset_status", d, 8'h00);
    @(posedge clk);
    #1;

    applyStimulus(1, 8'h5A, 2, 1'b0, 8'h5A, "conv5a");
    checkOutput("conv5a_strobes", 8'(strobeCnt), 8'd8);
    readReg(4'd0, d); checkOutput("conv5a_ctrl", d, 8'h04);

    applyStimulus(1, 8'hFF, 5, 1'b0, 8'hFF, "convff");
    tieLow = 1'b1;
    applyStimulus(1, 8'h00, 3, 1'b0, 8'h00, "conv00");
    tieLow = 1'b0;
    highs = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (uo_out[1]) highs++;
    end
    checkOutput("idle_pwm_zero", 8'(highs), 8'h00);

    thr = $urandom_range(0, 255);
    applyStimulus(0, thr, 7, 1'b0, 8'(thr), "settle0");

    for (int k = 0; k < 3; k++) begin
      thr = $urandom_range(0, 255);
      applyStimulus($urandom_range(1, 2), thr, $urandom_range(0, 7), 1'b0, 8'(thr), "rand");
    end

    // SETTLE rewritten inside bit 7: bit 7 keeps 512 cycles, the remaining bits use 256.
    thr = $urandom_range(0, 255);
    threshold = thr;
    chSel = 1;
    writeReg(4'd1, 8'd2);
    writeReg(4'd0, 8'h03);
    repeat (100) @(posedge clk);
    writeReg(4'd1, 8'd1);
    repeat (2304 - 1 - 101) @(posedge clk);
    #1;
    readReg(4'd2, d); checkOutput("settle_mid_early", d, expResult);
    @(posedge clk);
    #1;
    readReg(4'd2, d); checkOutput("settle_mid_result", d, 8'(thr));
    expResult = 8'(thr);

    // Continuous mode, threshold change between conversions, CONT cleared during the second.
    threshold = 8'h5A;
    chSel = 0;
    busyLow = 0;
    writeReg(4'd0, 8'h11);
    for (int i = 0; i < 2047; i++) begin
      @(posedge clk); #1;
      if (!uo_out[2]) busyLow++;
    end
    readReg(4'd2, d); checkOutput("cont_first_early", d, expResult);
    @(posedge clk);
    #1;
    readReg(4'd2, d); checkOutput("cont_first_result", d, 8'h5A);
    threshold = 8'hA5;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (!uo_out[2]) busyLow++;
    end
    writeReg(4'd0, 8'h0E);
    for (int i = 0; i < 1546; i++) begin
      @(posedge clk); #1;
      if (!uo_out[2]) busyLow++;
    end
    readReg(4'd2, d); checkOutput("cont_second_early", d, 8'h5A);
    @(posedge clk);
    #1;
    readReg(4'd2, d); checkOutput("cont_second_result", d, 8'hA5);
    readReg(4'd3, d); checkOutput("cont_stop_status", d, 8'h02);
    readReg(4'd0, d); checkOutput("cont_ctrl_ch_kept", d, 8'h00);
    checkOutput("cont_busy_held", 8'(busyLow), 8'h00);
    expResult = 8'hA5;

    // STATUS write on the completion edge: DONE still ends set.
    thr = $urandom_range(0, 255);
    threshold = thr;
    chSel = 1;
    writeReg(4'd0, 8'h03);
    repeat (2047) @(posedge clk);
    #1;
    writeReg(4'd3, 8'h00);
    readReg(4'd3, d); checkOutput("status_race_done", d, 8'h02);
    readReg(4'd2, d); checkOutput("status_race_result", d, 8'(thr));
    expResult = 8'(thr);
    writeReg(4'd3, 8'hFF);
    readReg(4'd3, d); checkOutput("status_clear", d, 8'h00);

    // Restart mid-conversion: RESULT untouched until a full conversion after the restart.
    threshold = 8'h33;
    chSel = 4;
    writeReg(4'd0, 8'h09);
    repeat (998) @(posedge clk);
    #1;
    threshold = 8'h77;
    writeReg(4'd0, 8'h09);
    repeat (2047) @(posedge clk);
    #1;
    readReg(4'd2, d); checkOutput("restart_early", d, expResult);
    readReg(4'd3, d); checkOutput("restart_early_status", d, 8'h01);
    @(posedge clk);
    #1;
    readReg(4'd2, d); checkOutput("restart_result", d, 8'h77);
    expResult = 8'h77;

    // Comparator glitches low on the last cycle of every bit.
`ifdef ANATOOL_SAR_MAJORITY_EN
    expG = 8'hC3;
`else
    expG = 8'h00;
`endif
    glitchEn = 1'b1;
    applyStimulus(1, 8'hC3, 6, 1'b0, expG, "glitch");
    glitchEn = 1'b0;

    // Reset in the middle of a continuous conversion.
    threshold = 8'h40;
    chSel = 5;
    writeReg(4'd1, 8'd3);
    writeReg(4'd0, 8'h1B);
    repeat (700) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    readReg(4'd0, d); checkOutput("rst_ctrl", d, 8'h00);
    readReg(4'd1, d); checkOutput("rst_settle", d, 8'h04);
    readReg(4'd2, d); checkOutput("rst_result", d, 8'h00);
    @(posedge clk);
    #1;
    readReg(4'd3, d); checkOutput("rst_status", d, 8'h00);
    checkOutput("rst_uo_out", uo_out, 8'h00);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
